// File: rtl/conv_output_serializer.sv
// Captures a full convolution output map in one cycle, then streams it word by
// word in ascending (channel, row, column) order over a valid/ready handshake.
module conv_output_serializer #(
    parameter int DATA_WIDTH = 16,
    parameter int ConvOut    = 28,
    parameter int DepthC     = 6,
    localparam int CH_W      = (DepthC > 1) ? $clog2(DepthC) : 1,
    localparam int IDX_W     = (ConvOut > 1) ? $clog2(ConvOut) : 1,
    localparam int WORDS     = ConvOut * ConvOut * DepthC,
    localparam int BUF_W     = WORDS * DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BUF_W-1:0]      convIn,
    output logic [DATA_WIDTH-1:0] outData,
    output logic                  outValid,
    input  logic                  outReady,
    output logic                  outLast,
    output logic [CH_W-1:0]       outChan,
    output logic [IDX_W-1:0]      outRow,
    output logic [IDX_W-1:0]      outCol,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t           state_q, state_d;
    logic [CH_W-1:0]  d_q, d_d;
    logic [IDX_W-1:0] r_q, r_d;
    logic [IDX_W-1:0] c_q, c_d;
    logic [BUF_W-1:0] buf_q, buf_d;
    logic             at_last;
    logic             xfer;
    int unsigned      k;

    // Word index into the flattened buffer for the current (d, r, c).
    always_comb begin
        k = (int'(d_q) * ConvOut + int'(r_q)) * ConvOut + int'(c_q);
    end

    always_comb begin
        at_last = (state_q == SEND) && (d_q == CH_W'(DepthC - 1)) &&
                  (r_q == IDX_W'(ConvOut - 1)) && (c_q == IDX_W'(ConvOut - 1));
        xfer    = (state_q == SEND) && outReady;

        // Outputs are Moore-style so they hold steady under backpressure and
        // fall to zero with the async reset regardless of buffer contents.
        outValid = (state_q == SEND);
        outData  = '0;
        outChan  = '0;
        outRow   = '0;
        outCol   = '0;
        if (state_q == SEND) begin
            outData = buf_q[k*DATA_WIDTH +: DATA_WIDTH];
            outChan = d_q;
            outRow  = r_q;
            outCol  = c_q;
        end
        outLast = at_last;
        busy    = (state_q == SEND) || (state_q == DONE);
        done    = (state_q == DONE);
    end

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        r_d     = r_q;
        c_d     = c_q;
        buf_d   = buf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    buf_d   = convIn;
                    d_d     = '0;
                    r_d     = '0;
                    c_d     = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (at_last) begin
                        state_d = DONE;
                    end else if (c_q == IDX_W'(ConvOut - 1)) begin
                        c_d = '0;
                        if (r_q == IDX_W'(ConvOut - 1)) begin
                            r_d = '0;
                            d_d = d_q + 1'b1;
                        end else begin
                            r_d = r_q + 1'b1;
                        end
                    end else begin
                        c_d = c_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            d_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            r_q     <= r_d;
            c_q     <= c_d;
        end
    end

    // Buffer needs no reset: its contents are only visible while in SEND.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

endmodule

// File: tb/tb_conv_output_serializer.sv
// Directed bench for conv_output_serializer on a 2x2x2 map of 16-bit words.
module tb_conv_output_serializer;

    localparam int DW    = 16;
    localparam int CO    = 2;
    localparam int DC    = 2;
    localparam int WORDS = CO * CO * DC;

    logic               clk;
    logic               reset;
    logic               start;
    logic [WORDS*DW-1:0] convIn;
    logic [DW-1:0]      outData;
    logic               outValid;
    logic               outReady;
    logic               outLast;
    logic [0:0]         outChan;
    logic [0:0]         outRow;
    logic [0:0]         outCol;
    logic               busy;
    logic               done;

    int errors = 0;
    int checks = 0;

    conv_output_serializer #(.DATA_WIDTH(DW), .ConvOut(CO), .DepthC(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .convIn(convIn),
        .outData(outData), .outValid(outValid), .outReady(outReady),
        .outLast(outLast), .outChan(outChan), .outRow(outRow), .outCol(outCol),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_map();
        for (int k = 0; k < WORDS; k++) convIn[k*DW +: DW] = 16'(16'h0100 + k);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        checks++;
        if ({outData, outValid, outLast, outChan, outRow, outCol, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_noclk: outs=%h expected all 0", {outData, outValid, outLast, busy, done});
        end
        tick();
        checks++;
        if ({outData, outValid, outLast, outChan, outRow, outCol, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_clk: outs=%h expected all 0", {outData, outValid, outLast, busy, done});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_full_stream();
        logic [DW-1:0] exp;
        outReady = 1'b1;
        pulse_start();
        for (int k = 0; k < WORDS; k++) begin
            exp = 16'(16'h0100 + k);
            checks++;
            if (outValid !== 1'b1 || outData !== exp || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL full_word%0d: valid=%b data=%h busy=%b done=%b expected 1 %h 1 0",
                         k, outValid, outData, busy, done, exp);
            end
            checks++;
            if (outChan !== 1'(k / 4) || outRow !== 1'((k / 2) % 2) || outCol !== 1'(k % 2) ||
                outLast !== (k == WORDS - 1)) begin
                errors++;
                $display("FAIL full_idx%0d: c/r/c/last=%b%b%b%b expected %0d%0d%0d%b",
                         k, outChan, outRow, outCol, outLast, k / 4, (k / 2) % 2, k % 2, k == WORDS - 1);
            end
            tick();
        end
        checks++;
        if (outValid !== 1'b0 || done !== 1'b1 || busy !== 1'b1 || outLast !== 1'b0) begin
            errors++;
            $display("FAIL full_done: valid=%b done=%b busy=%b last=%b expected 0 1 1 0",
                     outValid, done, busy, outLast);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || outValid !== 1'b0) begin
            errors++;
            $display("FAIL full_idle: done=%b busy=%b valid=%b expected 0 0 0", done, busy, outValid);
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] exp;
        outReady = 1'b1;
        pulse_start();
        tick();
        tick();
        outReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (outValid !== 1'b1 || outData !== 16'h0102 || {outChan, outRow, outCol} !== 3'b010 ||
                outLast !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b data=%h idx=%b last=%b expected 1 0102 010 0",
                         i, outValid, outData, {outChan, outRow, outCol}, outLast);
            end
            tick();
        end
        outReady = 1'b1;
        for (int k = 2; k < WORDS; k++) begin
            exp = 16'(16'h0100 + k);
            checks++;
            if (outValid !== 1'b1 || outData !== exp) begin
                errors++;
                $display("FAIL bp_word%0d: valid=%b data=%h expected 1 %h", k, outValid, outData, exp);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || outValid !== 1'b0) begin
            errors++;
            $display("FAIL bp_done: done=%b valid=%b expected 1 0", done, outValid);
        end
        tick();
    endtask

    task automatic test_input_change();
        logic [DW-1:0] exp;
        outReady = 1'b1;
        pulse_start();
        convIn = '1;
        for (int k = 0; k < WORDS; k++) begin
            exp = 16'(16'h0100 + k);
            checks++;
            if (outValid !== 1'b1 || outData !== exp) begin
                errors++;
                $display("FAIL inchg_word%0d: valid=%b data=%h expected 1 %h", k, outValid, outData, exp);
            end
            tick();
        end
        tick();
        load_map();
    endtask

    task automatic test_start_busy();
        logic [DW-1:0] exp;
        int ndone;
        outReady = 1'b1;
        ndone = 0;
        pulse_start();
        for (int k = 0; k < WORDS; k++) begin
            exp = 16'(16'h0100 + k);
            start = (k == 4);
            checks++;
            if (outValid !== 1'b1 || outData !== exp) begin
                errors++;
                $display("FAIL busy_word%0d: valid=%b data=%h expected 1 %h", k, outValid, outData, exp);
            end
            tick();
        end
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (done === 1'b1) ndone++;
            tick();
        end
        checks++;
        if (ndone != 1 || outValid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_single_done: pulses=%0d valid=%b busy=%b expected 1 0 0", ndone, outValid, busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] exp;
        outReady = 1'b1;
        pulse_start();
        for (int k = 0; k < 5; k++) tick();
        checks++;
        if (outValid !== 1'b1 || outData !== 16'h0105) begin
            errors++;
            $display("FAIL rmid_pre: valid=%b data=%h expected 1 0105", outValid, outData);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({outData, outValid, outLast, outChan, outRow, outCol, busy, done} !== '0) begin
            errors++;
            $display("FAIL rmid_async: data=%h valid=%b busy=%b done=%b expected all 0",
                     outData, outValid, busy, done);
        end
        tick();
        tick();
        checks++;
        if (done !== 1'b0 || outValid !== 1'b0) begin
            errors++;
            $display("FAIL rmid_nodone: done=%b valid=%b expected 0 0", done, outValid);
        end
        reset = 1'b0;
        tick();
        pulse_start();
        for (int k = 0; k < WORDS; k++) begin
            exp = 16'(16'h0100 + k);
            checks++;
            if (outValid !== 1'b1 || outData !== exp || outLast !== (k == WORDS - 1)) begin
                errors++;
                $display("FAIL rmid_word%0d: valid=%b data=%h last=%b expected 1 %h %b",
                         k, outValid, outData, outLast, exp, k == WORDS - 1);
            end
            tick();
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp;
        outReady = 1'b1;
        pulse_start();
        for (int k = 0; k < WORDS; k++) tick();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done: done=%b expected 1", done);
        end
        tick();
        start = 1'b1;
        checks++;
        if (outValid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: valid=%b busy=%b expected 0 0", outValid, busy);
        end
        tick();
        start = 1'b0;
        for (int k = 0; k < WORDS; k++) begin
            exp = 16'(16'h0100 + k);
            checks++;
            if (outValid !== 1'b1 || outData !== exp) begin
                errors++;
                $display("FAIL b2b_word%0d: valid=%b data=%h expected 1 %h", k, outValid, outData, exp);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done2: done=%b expected 1", done);
        end
        tick();
    endtask

    initial begin
        start    = 1'b0;
        outReady = 1'b1;
        convIn   = '0;
        load_map();
        test_reset();
        test_full_stream();
        test_backpressure();
        test_input_change();
        test_start_busy();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
